// File: rtl/dot_pkg.sv
// Shared constants and helpers for the dot-product engine.
// Operand vectors arrive as flat buses; lane_slice pulls one lane out of a
// bus that has been zero-extended to the largest supported geometry.
package dot_pkg;

    localparam int MAX_LANES = 16;
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] lane_slice(
        input logic [MAX_LANES*MAX_WIDTH-1:0] flat,
        input int unsigned                    idx,
        input int unsigned                    width
    );
        logic [MAX_LANES*MAX_WIDTH-1:0] shifted;
        shifted = flat >> (idx * width);
        return shifted[MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dot_tree_level.sv
// One registered level of the reduction tree: adds adjacent pairs of the
// incoming lanes (mod 2^WIDTH) and carries the beat's valid/last alongside.
module dot_tree_level
    import dot_pkg::*;
#(
    parameter int IN_COUNT = 4,
    parameter int WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [IN_COUNT*WIDTH-1:0]       in_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic [(IN_COUNT/2)*WIDTH-1:0]   out_data
);

    localparam int OUT_COUNT = IN_COUNT / 2;

    // Pairwise add and register; everything freezes while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            for (int j = 0; j < OUT_COUNT; j++) begin
                out_data[j*WIDTH +: WIDTH] <= in_data[(2*j)*WIDTH +: WIDTH]
                                            + in_data[(2*j+1)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/dot_product_pipe.sv
// Multi-lane dot-product engine with per-packet accumulation.
// Pipeline: stage M (lane multiplies) -> TREE_LVLS adder levels -> stage A
// (accumulator + output register). One global enable stalls every stage
// together whenever a completed sum is waiting and the consumer is not ready.
module dot_product_pipe
    import dot_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    localparam int TREE_LVLS = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*WIDTH-1:0]  a_flat,
    input  logic [LANES*WIDTH-1:0]  b_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
);

    logic                   en;
    logic [WIDTH-1:0]       a_lane [LANES];
    logic [WIDTH-1:0]       b_lane [LANES];

    logic [LANES*WIDTH-1:0] m_data;
    logic                   m_valid;
    logic                   m_last;

    logic [LANES*WIDTH-1:0] lvl_data [TREE_LVLS+1];
    logic [TREE_LVLS:0]     lvl_valid;
    logic [TREE_LVLS:0]     lvl_last;

    logic [WIDTH-1:0]       dot;
    logic                   tree_valid;
    logic                   tree_last;
    logic [WIDTH-1:0]       acc;
    logic                   first;
    logic [WIDTH-1:0]       sum;

    // The pipe may advance unless a finished sum is parked at the output.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Split the flat operand buses into per-lane values.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_lane[i] = WIDTH'(lane_slice((MAX_LANES*MAX_WIDTH)'(a_flat), i, WIDTH));
            b_lane[i] = WIDTH'(lane_slice((MAX_LANES*MAX_WIDTH)'(b_flat), i, WIDTH));
        end
    end

    // Stage M: per-lane products truncated to WIDTH, tagged with valid/last.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else if (en) begin
            m_valid <= in_valid;
            m_last  <= in_last;
            for (int i = 0; i < LANES; i++) begin
                m_data[i*WIDTH +: WIDTH] <= a_lane[i] * b_lane[i];
            end
        end
    end

    assign lvl_data[0]  = m_data;
    assign lvl_valid[0] = m_valid;
    assign lvl_last[0]  = m_last;

    // Reduction tree: level k halves the lane count; zero levels for one lane.
    for (genvar k = 0; k < TREE_LVLS; k++) begin : g_tree
        localparam int IN_N  = LANES >> k;
        localparam int OUT_N = IN_N / 2;

        logic [OUT_N*WIDTH-1:0] lvl_out;
        logic                   lvl_v;
        logic                   lvl_l;

        dot_tree_level #(
            .IN_COUNT (IN_N),
            .WIDTH    (WIDTH)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .in_valid  (lvl_valid[k]),
            .in_last   (lvl_last[k]),
            .in_data   (lvl_data[k][IN_N*WIDTH-1:0]),
            .out_valid (lvl_v),
            .out_last  (lvl_l),
            .out_data  (lvl_out)
        );

        assign lvl_data[k+1]  = (LANES*WIDTH)'(lvl_out);
        assign lvl_valid[k+1] = lvl_v;
        assign lvl_last[k+1]  = lvl_l;
    end

    assign dot        = lvl_data[TREE_LVLS][WIDTH-1:0];
    assign tree_valid = lvl_valid[TREE_LVLS];
    assign tree_last  = lvl_last[TREE_LVLS];

    // The first beat of a packet starts from zero instead of the stale acc.
    always_comb begin
        sum = (first ? '0 : acc) + dot;
    end

    // Stage A: accumulate non-last beats, publish the sum on the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= tree_valid && tree_last;
            if (tree_valid) begin
                if (tree_last) begin
                    out_data <= sum;
                    first    <= 1'b1;
                end else begin
                    acc      <= sum;
                    first    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_pipe.sv
// Self-checking bench for dot_product_pipe (LANES=4, WIDTH=32).
// A negedge monitor keeps a packet-level reference (running sum per packet,
// queue of completed sums) and scores every output handshake against it;
// directed sequences add latency, stall, reset and wrap-around checks.
module tb_dot_product_pipe;

    localparam int WIDTH = 32;
    localparam int LANES = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   in_last = 1'b0;
    logic [LANES*WIDTH-1:0] a_flat = '0;
    logic [LANES*WIDTH-1:0] b_flat = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [WIDTH-1:0]       out_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] partial = '0;
    logic [31:0] expQ[$];
    logic [31:0] obsLog[$];
    int          outCount = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData = '0;
    logic        readyExp;
    bit          randomDone = 1'b0;

    dot_product_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [LANES*WIDTH-1:0] lanes4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference dot product: sum of full products, reduced mod 2^32.
    function automatic logic [31:0] refDot(input logic [LANES*WIDTH-1:0] a,
                                           input logic [LANES*WIDTH-1:0] b);
        longint unsigned s;
        longint unsigned x;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            x = longint'(a[i*WIDTH +: WIDTH]) * longint'(b[i*WIDTH +: WIDTH]);
            s = (s + x) % 64'h1_0000_0000;
        end
        return s[31:0];
    endfunction

    // Packet-level reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            partial   = '0;
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            readyExp = !out_valid || out_ready;
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, readyExp});
            if (prevStall) begin
                checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
                checkOutput("stall_data", out_data, prevData);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0)
                    checkOutput("out_pending", {31'b0, expQ.size() != 0}, 32'd1);
                else
                    checkOutput("scoreboard", out_data, expQ.pop_front());
                outCount++;
                obsLog.push_back(out_data);
            end
            if (in_valid && readyExp) begin
                partial = partial + refDot(a_flat, b_flat);
                if (in_last) begin
                    expQ.push_back(partial);
                    partial = '0;
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
        end
    end

    // Present one beat and hold it until the edge that accepts it.
    task automatic applyStimulus(input logic [LANES*WIDTH-1:0] a,
                                 input logic [LANES*WIDTH-1:0] b,
                                 input logic last);
        logic ok;
        ok       = 1'b0;
        a_flat   = a;
        b_flat   = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = in_ready && !reset;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) checkOutput("accept_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stop driving, then poll (bounded) for the next output and compare it.
    task automatic waitForOutput(input string tag, input logic [31:0] expected);
        logic found;
        found    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_seen"}, {31'b0, found}, 32'd1);
        if (found) checkOutput(tag, out_data, expected);
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        logic [31:0] held;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single-beat packet with exact latency.
        $display("[TB] single-beat packet");
        applyStimulus(lanes4(1, 2, 3, 4), lanes4(5, 6, 7, 8), 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("lat_c1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_c2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_c3", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_c4_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("lat_c4_data", out_data, 32'd70);
        @(posedge clk); #1;
        checkOutput("after_handshake", {31'b0, out_valid}, 32'd0);

        // Three-beat packet with a two-cycle bubble.
        $display("[TB] three-beat packet");
        c0 = outCount;
        applyStimulus(lanes4(1, 1, 1, 1), lanes4(1, 2, 3, 4), 1'b0);
        idle(2);
        applyStimulus(lanes4(1, 1, 1, 1), lanes4(1, 2, 3, 4), 1'b0);
        applyStimulus(lanes4(1, 1, 1, 1), lanes4(1, 2, 3, 4), 1'b1);
        waitForOutput("three_beat", 32'd30);
        idle(6);
        checkOutput("three_beat_count", 32'(outCount - c0), 32'd1);

        // Wrap-around cases.
        $display("[TB] wrap-around");
        applyStimulus(lanes4(32'hFFFF_FFFF, 0, 0, 0), lanes4(2, 0, 0, 0), 1'b1);
        waitForOutput("wrap_mul", 32'hFFFF_FFFE);
        idle(2);
        applyStimulus(lanes4(32'h0001_0000, 0, 0, 0), lanes4(32'h0001_0000, 0, 0, 0), 1'b1);
        waitForOutput("wrap_sq", 32'd0);
        idle(2);
        applyStimulus(lanes4(32'hFFFF_FFFF, 0, 0, 0), lanes4(1, 0, 0, 0), 1'b0);
        applyStimulus(lanes4(1, 0, 0, 0), lanes4(1, 0, 0, 0), 1'b1);
        waitForOutput("wrap_acc", 32'd0);
        idle(4);

        // Backpressure: eight packets with a three-cycle stall mid-stream.
        $display("[TB] backpressure");
        c0 = obsLog.size();
        fork
            begin
                for (int k = 1; k <= 8; k++)
                    applyStimulus(lanes4(32'(k), 0, 0, 0), lanes4(1, 0, 0, 0), 1'b1);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
                checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
                held = out_data;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    checkOutput("bp_hold", out_data, held);
                    checkOutput("bp_in_ready_held", {31'b0, in_ready}, 32'd0);
                end
                out_ready = 1'b1;
            end
        join
        idle(15);
        checkOutput("bp_count", 32'(obsLog.size() - c0), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (c0 + j < obsLog.size())
                checkOutput("bp_order", obsLog[c0 + j], 32'(j + 1));
        end

        // Back-to-back last beats, output consumed every cycle.
        $display("[TB] back-to-back packets");
        applyStimulus(lanes4(1, 0, 0, 0), lanes4(3, 0, 0, 0), 1'b1);
        applyStimulus(lanes4(1, 0, 0, 0), lanes4(4, 0, 0, 0), 1'b1);
        waitForOutput("b2b_first", 32'd3);
        @(posedge clk); #1;
        checkOutput("b2b_valid_held", {31'b0, out_valid}, 32'd1);
        checkOutput("b2b_second", out_data, 32'd4);
        @(posedge clk); #1;
        checkOutput("b2b_drained", {31'b0, out_valid}, 32'd0);
        idle(3);

        // Reset mid-packet, with a last beat offered during the reset cycle.
        $display("[TB] reset mid-packet");
        c0 = outCount;
        applyStimulus(lanes4(1, 2, 3, 4), lanes4(1, 1, 1, 1), 1'b0);
        applyStimulus(lanes4(1, 2, 3, 4), lanes4(1, 1, 1, 1), 1'b0);
        in_last = 1'b1;
        reset   = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            checkOutput("midrst_quiet", {31'b0, out_valid}, 32'd0);
        end
        checkOutput("midrst_no_out", 32'(outCount - c0), 32'd0);
        applyStimulus(lanes4(1, 2, 3, 4), lanes4(1, 1, 1, 1), 1'b1);
        waitForOutput("midrst_fresh", 32'd10);
        idle(3);

        // Randomised traffic with random consumer backpressure.
        $display("[TB] random traffic");
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(3) == 0)
                        idle(1);
                    else
                        applyStimulus({$urandom, $urandom, $urandom, $urandom},
                                      {$urandom, $urandom, $urandom, $urandom},
                                      ($urandom_range(2) == 0) || (n == 399));
                end
                in_valid   = 1'b0;
                in_last    = 1'b0;
                randomDone = 1'b1;
            end
            begin
                while (!randomDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 100; n++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
        end
        #1;
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
